// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: 1..3 slices of staging with per-slice valid,
// stall/flush control, writeback mux, forwarding-hit detect and a retire counter.
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int STAGES = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              le,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] MemDataIn,
   input  logic [DATA_W-1:0] ALUDataIn,
   input  logic [REG_AW-1:0] WriteRegIn,
   input  logic              RegWriteIn,
   input  logic              MemtoRegIn,
   input  logic [REG_AW-1:0] src_a,
   input  logic [REG_AW-1:0] src_b,
   output logic              valid_out,
   output logic [DATA_W-1:0] MemDataOut,
   output logic [DATA_W-1:0] ALUDataOut,
   output logic [REG_AW-1:0] WriteRegOut,
   output logic              RegWriteOut,
   output logic              MemtoRegOut,
   output logic [DATA_W-1:0] wb_data_out,
   output logic              fwd_hit_a,
   output logic              fwd_hit_b,
   output logic [CNT_W-1:0]  retire_count
);

   generate
      if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
         $error("mem_wb_pipe: STAGES must be in 1..3");
      end
   endgenerate

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] mem_data;
      logic [DATA_W-1:0] alu_data;
      logic [REG_AW-1:0] write_reg;
      logic              reg_write;
      logic              mem_to_reg;
   } slice_t;

   slice_t           slice_in;
   slice_t           slice_q [STAGES];
   slice_t           slice_d [STAGES];
   logic [CNT_W-1:0] retire_q;
   logic [CNT_W-1:0] retire_d;
   slice_t           last;

   assign slice_in = '{valid:      valid_in,
                       mem_data:   MemDataIn,
                       alu_data:   ALUDataIn,
                       write_reg:  WriteRegIn,
                       reg_write:  RegWriteIn,
                       mem_to_reg: MemtoRegIn};

   // Next-state of the slice chain and retire counter: shift on le, squash slice 0 on flush.
   always_comb begin
      // NOTE: hold-by-default assignments first, so every path assigns every bit and no latch is inferred.
      slice_d  = slice_q;
      retire_d = retire_q;
      if (le) begin
         slice_d[0] = slice_in;
         for (int k = 1; k < STAGES; k++) begin
            slice_d[k] = slice_q[k-1];
         end
         if (slice_q[STAGES-1].valid) begin
            retire_d = retire_q + CNT_W'(1);
         end
      end
      // Flush only touches slice 0; the last slice may still retire on this edge.
      if (flush) begin
         slice_d[0] = '0;
      end
   end

   // State registers with asynchronous clear of every slice and the counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the slice array is a handful of pipeline flops, not a RAM, so every entry is cleared on reset.
         for (int k = 0; k < STAGES; k++) begin
            slice_q[k] <= '0;
         end
         retire_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so all slices update from pre-edge values.
         slice_q  <= slice_d;
         retire_q <= retire_d;
      end
   end

   assign last         = slice_q[STAGES-1];
   assign valid_out    = last.valid;
   assign MemDataOut   = last.mem_data;
   assign ALUDataOut   = last.alu_data;
   assign WriteRegOut  = last.write_reg;
   assign MemtoRegOut  = last.mem_to_reg;
   // A bubble keeps its stored RegWrite but must never write the register file.
   assign RegWriteOut  = last.reg_write & last.valid;
   assign wb_data_out  = last.mem_to_reg ? last.mem_data : last.alu_data;
   // Register 0 is hardwired to zero, so it never forwards.
   assign fwd_hit_a    = RegWriteOut & (last.write_reg != '0) & (last.write_reg == src_a);
   assign fwd_hit_b    = RegWriteOut & (last.write_reg != '0) & (last.write_reg == src_b);
   assign retire_count = retire_q;

endmodule
